// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates the instruction-fetch (IF) port and the MEM-stage port onto
//   the single request interface of the RAM1/UART memory controller. Each
//   access carries a fresh action token. The command is held stable until
//   the controller reports completion or the access times out. Read data
//   is returned to the port that owns the access.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   if_req/if_addr    IF read request (level) and address
//   if_ack/if_rdata   one-cycle IF completion pulse, IF read data (held)
//   mem_req/rd/wr     MEM-stage request (level) and command
//   mem_addr/wdata    MEM-stage address and write data
//   mem_ack/mem_rdata one-cycle MEM completion pulse, MEM read data (held)
//   stall             pipeline stall: a request is pending and not yet acked
//   mc_*              controller request: valid, command, address, data, token
//   mc_done/result    controller completion (token already matched) and read data
//   bus_err           sticky error (timeout or MEM request with no command)
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int ACT_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              mc_need_to_work,
  output logic              mc_rd,
  output logic              mc_wr,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_value,
  output logic [ACT_W-1:0]  mc_act,
  input  logic              mc_done,
  input  logic [DATA_W-1:0] mc_result,
  output logic              bus_err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic               owner_mem, owner_mem_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               ntw_nxt, rd_nxt, wr_nxt, err_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [DATA_W-1:0]  value_nxt, if_rdata_nxt, mem_rdata_nxt;
  logic [ACT_W-1:0]   act_nxt;
  logic               grant;

  // Value returned to a reader whose access was aborted.
  function automatic logic [DATA_W-1:0] abort_fill();
    return {DATA_W{1'b1}};
  endfunction

  always_comb begin
    state_nxt     = state;
    owner_mem_nxt = owner_mem;
    timer_nxt     = timer;
    ntw_nxt       = mc_need_to_work;
    rd_nxt        = mc_rd;
    wr_nxt        = mc_wr;
    addr_nxt      = mc_addr;
    value_nxt     = mc_value;
    act_nxt       = mc_act;
    err_nxt       = bus_err;
    if_rdata_nxt  = if_rdata;
    mem_rdata_nxt = mem_rdata;
    grant         = 1'b0;

    case (state)
      IDLE: begin
        if (mem_req) begin
          owner_mem_nxt = 1'b1;
          // A request flagged as both read and write is served as a write.
          if (mem_wr) begin
            addr_nxt  = mem_addr;
            value_nxt = mem_wdata;
            wr_nxt    = 1'b1;
            rd_nxt    = 1'b0;
            grant     = 1'b1;
          end else if (mem_rd) begin
            addr_nxt = mem_addr;
            rd_nxt   = 1'b1;
            wr_nxt   = 1'b0;
            grant    = 1'b1;
          end else begin
            // No command: acknowledge with an error, never touch the controller.
            err_nxt   = 1'b1;
            state_nxt = RESP;
          end
        end else if (if_req) begin
          owner_mem_nxt = 1'b0;
          addr_nxt      = if_addr;
          rd_nxt        = 1'b1;
          wr_nxt        = 1'b0;
          grant         = 1'b1;
        end

        if (grant) begin
          // New token per access, so a late done from an old access cannot match.
          act_nxt   = mc_act + ACT_W'(1);
          ntw_nxt   = 1'b1;
          timer_nxt = '0;
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        timer_nxt = timer + TMR_W'(1);
        if (mc_done) begin
          if (!mc_wr) begin
            if (owner_mem) mem_rdata_nxt = mc_result;
            else           if_rdata_nxt  = mc_result;
          end
          ntw_nxt   = 1'b0;
          state_nxt = RESP;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          err_nxt = 1'b1;
          if (!mc_wr) begin
            if (owner_mem) mem_rdata_nxt = abort_fill();
            else           if_rdata_nxt  = abort_fill();
          end
          ntw_nxt   = 1'b0;
          state_nxt = RESP;
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      owner_mem       <= 1'b0;
      timer           <= '0;
      mc_need_to_work <= 1'b0;
      mc_rd           <= 1'b0;
      mc_wr           <= 1'b0;
      mc_addr         <= '0;
      mc_value        <= '0;
      mc_act          <= '0;
      bus_err         <= 1'b0;
      if_rdata        <= '0;
      mem_rdata       <= '0;
    end else begin
      state           <= state_nxt;
      owner_mem       <= owner_mem_nxt;
      timer           <= timer_nxt;
      mc_need_to_work <= ntw_nxt;
      mc_rd           <= rd_nxt;
      mc_wr           <= wr_nxt;
      mc_addr         <= addr_nxt;
      mc_value        <= value_nxt;
      mc_act          <= act_nxt;
      bus_err         <= err_nxt;
      if_rdata        <= if_rdata_nxt;
      mem_rdata       <= mem_rdata_nxt;
    end
  end

  // Acks are decoded from RESP so they vanish the instant reset asserts.
  assign if_ack  = (state == RESP) && !owner_mem;
  assign mem_ack = (state == RESP) &&  owner_mem;
  assign stall   = (mem_req & ~mem_ack) | (if_req & ~if_ack);

endmodule
